// File: rtl/mw_stage_reg_pkg.sv
// rtl/mw_stage_reg_pkg.sv - shared codes, control-field struct and defaults for the MEM/WB stage
package mw_stage_reg_pkg;

    // Write-data source select; 2'b11 is reserved and falls back to the ALU path
    typedef enum logic [1:0] {
        WD_ALU = 2'b00,
        WD_MEM = 2'b01,
        WD_PC8 = 2'b10
    } wd_sel_e;

    // Load flavours; unlisted codes behave as a full-word load
    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_BU = 3'b001,
        LD_B  = 3'b010,
        LD_HU = 3'b011,
        LD_H  = 3'b100
    } ld_type_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    // Width-independent control fields held in the W stage
    typedef struct packed {
        logic       valid;
        logic       grfwe;
        logic [4:0] addr;
        logic [1:0] tnew;
        logic [1:0] wd_sel;
        logic [2:0] ld_type;
        logic [1:0] byte_off;
    } w_ctrl_t;

    localparam w_ctrl_t CTRL_BUBBLE = '0;

    // Result latency one stage later, never going below zero
    function automatic logic [1:0] tnew_dec(input logic [1:0] tnew);
        return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
    endfunction

endpackage

// File: rtl/mw_stage_reg_load_ext.sv
// rtl/mw_stage_reg_load_ext.sv - byte/half/word selection and extension of loaded data
module load_ext
    import mw_stage_reg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic [1:0]       off_i,
    input  logic [2:0]       type_i,
    output logic [WIDTH-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the aligned word
    always_comb begin
        byte_sel = word_i[7:0];
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        // The low offset bit is irrelevant for halfword loads
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // Extend the selected slice according to the load flavour
    always_comb begin
        data_o = word_i;
        case (type_i)
            LD_BU:   data_o = {{(WIDTH-8){1'b0}}, byte_sel};
            LD_B:    data_o = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            LD_HU:   data_o = {{(WIDTH-16){1'b0}}, half_sel};
            LD_H:    data_o = {{(WIDTH-16){half_sel[15]}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mw_stage_reg.sv
// rtl/mw_stage_reg.sv - MEM/WB pipeline register, write-back data mux and retire counter
module mw_stage_reg
    import mw_stage_reg_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             M_Valid,
    input  logic             M_GRFWE,
    input  logic [4:0]       M_Addr,
    input  logic [1:0]       M_WDSel,
    input  logic [WIDTH-1:0] M_ALUOut,
    input  logic [WIDTH-1:0] M_DMRD,
    input  logic [1:0]       M_ByteOff,
    input  logic [2:0]       M_LoadType,
    input  logic [WIDTH-1:0] M_PC,
    input  logic [1:0]       M_Tnew,
    output logic             W_Valid,
    output logic             W_GRFWE,
    output logic [4:0]       W_Addr,
    output logic [WIDTH-1:0] W_WD,
    output logic [1:0]       W_Tnew,
    output logic [WIDTH-1:0] W_PC,
    output logic [31:0]      W_RetireCnt
);

    w_ctrl_t          ctrl_q, ctrl_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [WIDTH-1:0] dmrd_q, dmrd_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      retire_cnt_q;
    logic [31:0]      retire_cnt_d;
    logic             capture_we;
    logic [WIDTH-1:0] load_data;

    // A bubble or a $0 destination must never produce a register write
    assign capture_we = M_GRFWE & M_Valid & (M_Addr != 5'd0);

    // Next stage contents: flush beats advance, otherwise hold
    always_comb begin
        ctrl_d = ctrl_q;
        alu_d  = alu_q;
        dmrd_d = dmrd_q;
        pc_d   = pc_q;
        if (flush) begin
            ctrl_d = CTRL_BUBBLE;
            alu_d  = '0;
            dmrd_d = '0;
            pc_d   = RESET_PC;
        end else if (en) begin
            ctrl_d.valid    = M_Valid;
            ctrl_d.grfwe    = capture_we;
            ctrl_d.addr     = capture_we ? M_Addr : 5'd0;
            ctrl_d.tnew     = tnew_dec(M_Tnew);
            ctrl_d.wd_sel   = M_WDSel;
            ctrl_d.ld_type  = M_LoadType;
            ctrl_d.byte_off = M_ByteOff;
            alu_d           = M_ALUOut;
            dmrd_d          = M_DMRD;
            pc_d            = M_PC;
        end
    end

    // The instruction in W retires whenever the stage advances past it, flush or not
    assign retire_cnt_d = retire_cnt_q + {31'd0, ctrl_q.valid & en};

    // Stage registers and retire counter; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q       <= CTRL_BUBBLE;
            alu_q        <= '0;
            dmrd_q       <= '0;
            pc_q         <= RESET_PC;
            retire_cnt_q <= 32'd0;
        end else begin
            ctrl_q       <= ctrl_d;
            alu_q        <= alu_d;
            dmrd_q       <= dmrd_d;
            pc_q         <= pc_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    load_ext #(
        .WIDTH (WIDTH)
    ) u_load_ext (
        .word_i (dmrd_q),
        .off_i  (ctrl_q.byte_off),
        .type_i (ctrl_q.ld_type),
        .data_o (load_data)
    );

    // Write-back data from stored fields only, so there is no input-to-output path
    always_comb begin
        case (ctrl_q.wd_sel)
            WD_MEM:  W_WD = load_data;
            WD_PC8:  W_WD = pc_q + WIDTH'(8);
            default: W_WD = alu_q;
        endcase
    end

    assign W_Valid     = ctrl_q.valid;
    assign W_GRFWE     = ctrl_q.grfwe;
    assign W_Addr      = ctrl_q.addr;
    assign W_Tnew      = ctrl_q.tnew;
    assign W_PC        = pc_q;
    assign W_RetireCnt = retire_cnt_q;

endmodule

// File: tb/tb_mw_stage_reg.sv
// tb/tb_mw_stage_reg.sv - randomized self-checking bench for mw_stage_reg against a reference model
module tb_mw_stage_reg;

    logic        clk = 1'b0;
    logic        reset, en, flush;
    logic        M_Valid, M_GRFWE;
    logic [4:0]  M_Addr;
    logic [1:0]  M_WDSel, M_ByteOff, M_Tnew;
    logic [2:0]  M_LoadType;
    logic [31:0] M_ALUOut, M_DMRD, M_PC;
    logic        W_Valid, W_GRFWE;
    logic [4:0]  W_Addr;
    logic [1:0]  W_Tnew;
    logic [31:0] W_WD, W_PC, W_RetireCnt;

    int checks = 0;
    int failures = 0;

    logic        exp_valid, exp_we;
    logic [4:0]  exp_addr;
    logic [1:0]  exp_tnew;
    logic [31:0] exp_wd, exp_pc, exp_cnt;

    always #5 clk = ~clk;

    mw_stage_reg #(.WIDTH(32), .RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .M_Valid(M_Valid), .M_GRFWE(M_GRFWE), .M_Addr(M_Addr), .M_WDSel(M_WDSel),
        .M_ALUOut(M_ALUOut), .M_DMRD(M_DMRD), .M_ByteOff(M_ByteOff),
        .M_LoadType(M_LoadType), .M_PC(M_PC), .M_Tnew(M_Tnew),
        .W_Valid(W_Valid), .W_GRFWE(W_GRFWE), .W_Addr(W_Addr), .W_WD(W_WD),
        .W_Tnew(W_Tnew), .W_PC(W_PC), .W_RetireCnt(W_RetireCnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write-back value straight from the load/select rules, using shifts and arithmetic
    function automatic logic [31:0] model_wd(input logic [1:0] sel, input logic [31:0] alu,
                                             input logic [31:0] dmrd, input logic [31:0] pc,
                                             input logic [1:0] off, input logic [2:0] lt);
        logic [31:0] b, h;
        int sh;
        sh = 8 * int'(off);
        b = (dmrd >> sh) & 32'h0000_00FF;
        h = (off >= 2'd2) ? (dmrd >> 16) : (dmrd & 32'h0000_FFFF);
        if (sel == 2'd2) return pc + 32'd8;
        if (sel != 2'd1) return alu;
        case (lt)
            3'd1:    return b;
            3'd2:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            3'd3:    return h;
            3'd4:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            default: return dmrd;
        endcase
    endfunction

    task automatic model_bubble();
        exp_valid = 1'b0; exp_we = 1'b0; exp_addr = 5'd0; exp_tnew = 2'd0;
        exp_wd = 32'd0; exp_pc = 32'h0000_3000;
    endtask

    task automatic check_all();
        chk("w_valid", {31'd0, W_Valid}, {31'd0, exp_valid});
        chk("w_grfwe", {31'd0, W_GRFWE}, {31'd0, exp_we});
        chk("w_addr", {27'd0, W_Addr}, {27'd0, exp_addr});
        chk("w_tnew", {30'd0, W_Tnew}, {30'd0, exp_tnew});
        chk("w_wd", W_WD, exp_wd);
        chk("w_pc", W_PC, exp_pc);
        chk("w_retire", W_RetireCnt, exp_cnt);
    endtask

    // Advance the model by one edge from the current inputs, then clock the DUT and compare
    task automatic tick();
        if (reset) begin
            model_bubble();
            exp_cnt = 32'd0;
        end else begin
            if (en && exp_valid) exp_cnt = exp_cnt + 32'd1;
            if (flush) model_bubble();
            else if (en) begin
                exp_valid = M_Valid;
                exp_we    = M_Valid && M_GRFWE && (M_Addr != 5'd0);
                exp_addr  = exp_we ? M_Addr : 5'd0;
                exp_tnew  = (M_Tnew > 2'd0) ? M_Tnew - 2'd1 : 2'd0;
                exp_pc    = M_PC;
                exp_wd    = model_wd(M_WDSel, M_ALUOut, M_DMRD, M_PC, M_ByteOff, M_LoadType);
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive_m(input logic v, input logic we, input logic [4:0] a, input logic [1:0] sel,
                           input logic [31:0] alu, input logic [31:0] dmrd, input logic [1:0] off,
                           input logic [2:0] lt, input logic [31:0] pc, input logic [1:0] tn);
        M_Valid = v; M_GRFWE = we; M_Addr = a; M_WDSel = sel; M_ALUOut = alu; M_DMRD = dmrd;
        M_ByteOff = off; M_LoadType = lt; M_PC = pc; M_Tnew = tn;
    endtask

    initial begin
        exp_cnt = 32'd0;
        model_bubble();
        reset = 1'b1; en = 1'b0; flush = 1'b0;
        drive_m(1'b1, 1'b1, 5'd7, 2'd0, 32'h1111_2222, 32'h3333_4444, 2'd1, 3'd0, 32'h4000, 2'd2);

        tick(); tick();
        chk("rst_pc", W_PC, 32'h0000_3000);
        chk("rst_cnt", W_RetireCnt, 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        en = 1'b1;
        drive_m(1'b1, 1'b1, 5'd8, 2'd1, 32'h0, 32'h80FF_1234, 2'd3, 3'd2, 32'h3004, 2'd0);
        tick();
        chk("lb_wd", W_WD, 32'hFFFF_FF80);
        chk("lb_addr", {27'd0, W_Addr}, 32'd8);
        M_LoadType = 3'd1;
        tick();
        chk("lbu_wd", W_WD, 32'h0000_0080);

        drive_m(1'b1, 1'b1, 5'd31, 2'd2, 32'hDEAD_BEEF, 32'h0, 2'd0, 3'd0, 32'h0000_3010, 2'd0);
        tick();
        chk("jal_wd", W_WD, 32'h0000_3018);
        M_Tnew = 2'd1;
        tick();
        chk("tnew1", {30'd0, W_Tnew}, 32'd0);
        M_Tnew = 2'd3;
        tick();
        chk("tnew3", {30'd0, W_Tnew}, 32'd2);

        drive_m(1'b1, 1'b1, 5'd0, 2'd0, 32'h55, 32'h0, 2'd0, 3'd0, 32'h3020, 2'd0);
        tick();
        chk("zero_dst_we", {31'd0, W_GRFWE}, 32'd0);
        drive_m(1'b0, 1'b1, 5'd5, 2'd0, 32'h66, 32'h0, 2'd0, 3'd0, 32'h3024, 2'd0);
        tick();
        chk("bubble_addr", {27'd0, W_Addr}, 32'd0);

        drive_m(1'b1, 1'b1, 5'd9, 2'd0, 32'h77, 32'h0, 2'd0, 3'd0, 32'h3028, 2'd0);
        tick();
        en = 1'b0; flush = 1'b1;
        tick();
        chk("flush_valid", {31'd0, W_Valid}, 32'd0);
        flush = 1'b0;

        force dut.retire_cnt_d = 32'hFFFF_FFFF;
        exp_cnt = 32'hFFFF_FFFF;
        tick();
        release dut.retire_cnt_d;
        en = 1'b1;
        tick();
        tick();
        chk("cnt_wrap", W_RetireCnt, 32'd0);

        en = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            en    = ($urandom_range(0, 3) != 0);
            drive_m($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
                    ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    2'($urandom_range(0, 3)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), $urandom, 2'($urandom_range(0, 3)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
